// File: rtl/i2c_reg_arbiter.sv
// -----------------------------------------------------------------------------
// i2c_reg_arbiter
//
// Shared I2C write engine for the audio codec control bus. N_REQ requesters
// are served round-robin. Each request is one codec register write (7-bit
// register address, 9-bit data), sent as a 3-byte I2C frame
// {DEV_ADDR, W=0, reg_addr, data}, MSB first, with START/STOP, one ACK slot
// after every byte and quarter-bit timing of CLK_DIV clocks per quarter.
//
// Ports
//   i_clk       system clock
//   i_rst_n     asynchronous active-low reset
//   i_req       per-requester level request, held until o_gnt
//   i_reg_addr  7-bit register address, slice k for requester k
//   i_reg_data  9-bit register data, slice k for requester k
//   i_sda_in    sampled SDA line, read in the ACK slots
//   o_gnt       one-cycle one-hot grant; address/data captured in that cycle
//   o_done      one-cycle pulse to the granted requester at frame end
//   o_err       pulses with o_done when the frame was NACKed
//   o_busy      high whenever a frame is in progress
//   o_sclk      SCL
//   o_sdat      SDA drive value
//   o_oen       1 = drive SDA, 0 = release (ACK slots)
//
// Build option
//   I2C_ACK_CHECK_EN  when defined, a NACK ends the frame after its ACK slot
//                     and raises o_err; when undefined, i_sda_in is ignored,
//                     all three bytes are always sent and o_err stays 0.
// -----------------------------------------------------------------------------
module i2c_reg_arbiter #(
   parameter int         N_REQ    = 2,
   parameter int         CLK_DIV  = 4,
   parameter logic [6:0] DEV_ADDR = 7'b0011010
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic [N_REQ-1:0]   i_req,
   input  logic [7*N_REQ-1:0] i_reg_addr,
   input  logic [9*N_REQ-1:0] i_reg_data,
   input  logic               i_sda_in,
   output logic [N_REQ-1:0]   o_gnt,
   output logic [N_REQ-1:0]   o_done,
   output logic               o_err,
   output logic               o_busy,
   output logic               o_sclk,
   output logic               o_sdat,
   output logic               o_oen
);

   localparam int RRW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CW  = $clog2(CLK_DIV);

   typedef enum logic [2:0] {S_IDLE, S_START, S_BIT, S_ACK, S_STOP, S_GAP} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;      // clocks within the current quarter
   logic [1:0]      qtr_q, qtr_d;      // quarter within the current phase
   logic [2:0]      bit_q, bit_d;
   logic [1:0]      byte_q, byte_d;
   logic [23:0]     frame_q, frame_d;  // current byte is always in [23:16]
   logic [RRW-1:0]  owner_q, owner_d;  // requester of the frame in flight
   logic [RRW-1:0]  rr_q, rr_d;        // last granted requester
   logic            run_q;             // blocks grants while reset is applied

   logic [6:0]      req_addr [N_REQ];
   logic [8:0]      req_data [N_REQ];
   logic            tick;
   logic            gnt_found;
   logic [RRW-1:0]  gnt_idx;
   logic [RRW-1:0]  cand;
   logic            grant_ok;
   logic            last_gap;
   logic            abort;

   genvar gi;
   generate
      for (gi = 0; gi < N_REQ; gi++) begin : g_slice
         assign req_addr[gi] = i_reg_addr[7*gi +: 7];
         assign req_data[gi] = i_reg_data[9*gi +: 9];
      end
   endgenerate

   assign tick     = (cnt_q == CW'(CLK_DIV - 1));
   assign last_gap = (state_q == S_GAP) && tick && (qtr_q == 2'd3);
   assign grant_ok = (state_q == S_IDLE) && gnt_found && run_q;

`ifdef I2C_ACK_CHECK_EN
   logic nack_q, nack_d;
   assign abort = nack_q;
`else
   logic unused_sda;
   assign unused_sda = i_sda_in;
   assign abort      = 1'b0;
`endif

   // Round-robin search starting one past the last granted requester.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      cand      = '0;
      for (int i = 0; i < N_REQ; i++) begin
         cand = RRW'((int'(rr_q) + 1 + i) % N_REQ);
         if (!gnt_found && i_req[cand]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand;
         end
      end
   end

   // State register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         qtr_q   <= '0;
         bit_q   <= '0;
         byte_q  <= '0;
         frame_q <= '0;
         owner_q <= '0;
         rr_q    <= RRW'(N_REQ - 1);
         run_q   <= 1'b0;
`ifdef I2C_ACK_CHECK_EN
         nack_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         qtr_q   <= qtr_d;
         bit_q   <= bit_d;
         byte_q  <= byte_d;
         frame_q <= frame_d;
         owner_q <= owner_d;
         rr_q    <= rr_d;
         run_q   <= 1'b1;
`ifdef I2C_ACK_CHECK_EN
         nack_q  <= nack_d;
`endif
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      qtr_d   = qtr_q;
      bit_d   = bit_q;
      byte_d  = byte_q;
      frame_d = frame_q;
      owner_d = owner_q;
      rr_d    = rr_q;
`ifdef I2C_ACK_CHECK_EN
      nack_d  = nack_q;
`endif
      if (state_q != S_IDLE) begin
         cnt_d = tick ? '0 : cnt_q + CW'(1);
      end
      case (state_q)
         S_IDLE: begin
            if (grant_ok) begin
               state_d = S_START;
               cnt_d   = '0;
               qtr_d   = '0;
               frame_d = {DEV_ADDR, 1'b0, req_addr[gnt_idx], req_data[gnt_idx]};
               owner_d = gnt_idx;
               rr_d    = gnt_idx;
`ifdef I2C_ACK_CHECK_EN
               nack_d  = 1'b0;
`endif
            end
         end
         S_START: begin
            if (tick) begin
               qtr_d = qtr_q + 2'd1;
               if (qtr_q == 2'd1) begin
                  state_d = S_BIT;
                  qtr_d   = '0;
                  bit_d   = '0;
                  byte_d  = '0;
               end
            end
         end
         S_BIT: begin
            if (tick) begin
               qtr_d = qtr_q + 2'd1;
               if (qtr_q == 2'd3) begin
                  if (bit_q == 3'd7) state_d = S_ACK;
                  else               bit_d   = bit_q + 3'd1;
               end
            end
         end
         S_ACK: begin
            if (tick) begin
               qtr_d = qtr_q + 2'd1;
`ifdef I2C_ACK_CHECK_EN
               // ACK is sampled at the q1->q2 boundary, mid SCL-high.
               if (qtr_q == 2'd1) nack_d = i_sda_in;
`endif
               if (qtr_q == 2'd3) begin
                  if (byte_q == 2'd2 || abort) begin
                     state_d = S_STOP;
                  end else begin
                     state_d = S_BIT;
                     byte_d  = byte_q + 2'd1;
                     bit_d   = '0;
                     frame_d = {frame_q[15:0], 8'h00};
                  end
               end
            end
         end
         S_STOP: begin
            if (tick) begin
               qtr_d = qtr_q + 2'd1;
               if (qtr_q == 2'd2) begin
                  state_d = S_GAP;
                  qtr_d   = '0;
               end
            end
         end
         S_GAP: begin
            if (tick) begin
               qtr_d = qtr_q + 2'd1;
               if (qtr_q == 2'd3) state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      o_sclk = 1'b1;
      o_sdat = 1'b1;
      o_oen  = 1'b1;
      o_busy = (state_q != S_IDLE);
      o_gnt  = '0;
      o_done = '0;
      o_err  = 1'b0;
      case (state_q)
         S_IDLE:  if (grant_ok) o_gnt[gnt_idx] = 1'b1;
         S_START: o_sdat = (qtr_q == 2'd0);
         S_BIT: begin
            o_sclk = (qtr_q == 2'd1) || (qtr_q == 2'd2);
            o_sdat = frame_q[5'd23 - {2'b00, bit_q}];
         end
         S_ACK: begin
            o_sclk = (qtr_q == 2'd1) || (qtr_q == 2'd2);
            o_oen  = 1'b0;
         end
         S_STOP: begin
            o_sclk = (qtr_q != 2'd0);
            o_sdat = (qtr_q == 2'd2);
         end
         S_GAP: begin
            if (last_gap) begin
               o_done[owner_q] = 1'b1;
               o_err           = abort;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: doc/i2c_reg_arbiter.md
# i2c_reg_arbiter

Shared I2C write engine for the audio codec control bus. It serves N_REQ requesters, for example the power-up initializer and the runtime volume/mute control. Each request carries one codec register write (7-bit register address, 9-bit data), and the block serialises it as a 3-byte I2C frame with START/STOP and quarter-period bit timing. Requesters are granted round-robin; one frame is on the bus at a time.

## Interface
- N_REQ, 2, number of requesters (≥1)
- CLK_DIV, 4, i_clk cycles per I2C quarter-bit (≥2)
- DEV_ADDR, 7'b0011010, 7-bit codec slave address
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous, active-low reset
- i_req  in  N_REQ  per-requester write request, level, held until o_gnt
- i_reg_addr  in  7*N_REQ  register address, slice k for requester k
- i_reg_data  in  9*N_REQ  register data, slice k for requester k
- i_sda_in  in  1  sampled SDA line (ACK input)
- o_gnt  out  N_REQ  one-cycle one-hot pulse; the addr/data slice is captured this cycle
- o_done  out  N_REQ  one-cycle pulse to the granted requester at frame end
- o_err  out  1  one-cycle pulse with o_done when the frame was NACKed
- o_busy  out  1  high in every state except IDLE
- o_sclk  out  1  SCL
- o_sdat  out  1  SDA drive value
- o_oen  out  1  1 = drive SDA, 0 = release (ACK slots)

## Operation
- Frame: {DEV_ADDR, 1'b0, reg_addr[6:0], data[8:0]}, 24 bits, MSB first, 3 bytes; each byte is followed by an ACK slot.
- States:
  - IDLE: SCL=1, SDA=1, oen=1. If any i_req is set, grant per round-robin, latch frame, go to START.
  - START: 2 quarters. q0 SCL=1 SDA=1; q1 SCL=1 SDA=0. Then BIT with bit=0, byte=0.
  - BIT: 4 quarters per bit. SDA = frame bit, updated at q0 start; SCL = 0,1,1,0 in q0..q3. After bit 7, go to ACK.
  - ACK: same SCL shape, oen=0, i_sda_in sampled at the q1→q2 boundary. If byte<2: byte+1, shift frame, go to BIT. Else go to STOP.
  - STOP: 3 quarters. q0 SCL=0 SDA=0; q1 SCL=1 SDA=0; q2 SCL=1 SDA=1. Then GAP.
  - GAP: 4 quarters at SCL=1 SDA=1 (bus free time). On its last cycle, pulse o_done[k] and return to IDLE.
- Round-robin: search starts at the index after the last granted requester. After reset, requester 0 has top priority.
- Requests are not queued. An i_req still high after its o_done is treated as a new request.
- Quarter counter: 0..CLK_DIV-1. It is cleared on the grant and advances only outside IDLE.

## Timing
- Reset values:
  - Outputs: o_sclk=1, o_sdat=1, o_oen=1; o_gnt, o_done, o_err, o_busy all 0.
  - Internal: state IDLE, round-robin pointer at N_REQ-1.
- Grant at cycle T (registered, combinational from i_req in IDLE).
- o_busy rises at T+1.
- o_done at T+117·CLK_DIV (2+108+3+4 quarters).
- Next grant no earlier than T+117·CLK_DIV+1.
- Simultaneous requests: exactly one o_gnt bit per grant cycle.
- i_req dropped before a grant: nothing is issued.
- Reset mid-frame: all state and outputs return to reset values immediately. A partial frame is not resumed, and no o_done is issued for it.

## Configuration
- I2C_ACK_CHECK_EN defined:
  - A sampled ACK of 1 (NACK) aborts the frame; the remaining bytes are skipped.
  - The block goes to STOP at the end of that ACK slot, then GAP.
  - o_done and o_err pulse together.
- Undefined: i_sda_in is ignored, all 3 bytes are always sent, and o_err is tied to 0.

## Test plan
- CLK_DIV=2, req0 with addr 7'h04, data 9'h015:
  - o_gnt=01, and bytes 0x34, 0x08, 0x15 appear on SDA with SCL high in q1/q2.
  - oen=0 in the 3 ACK slots.
  - o_done=01 exactly 234 cycles after the grant.
- i_req=11 held continuously: grants alternate 01,10,01,10, each spaced 117·CLK_DIV+1 cycles.
- I2C_ACK_CHECK_EN defined, i_sda_in=1 in the first ACK slot:
  - STOP follows byte 0, and o_done plus o_err pulse at 45 quarters after the grant.
  - Without the macro, the same stimulus gives a full frame with o_err=0.
- i_rst_n low during byte 1 of a frame:
  - Outputs are at reset values while reset is held.
  - After release, the still-high req0 is re-granted and a complete frame is sent.
- Requester 1 pulses i_req for 1 cycle while requester 0 is mid-frame: no grant to requester 1 and no frame is issued for it.
